// File: rtl/byte_stream_serializer.sv
// byte_stream_serializer: 4-entry byte FIFO feeding a UART-style serial
// framer (start bit, 8 data bits LSB first, optional parity, stop bit).
// Each bit lasts BIT_CYCLES clocks. Define SERIALIZER_PARITY_EN to add
// an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered byte
// START  | start bit (line low)
// DATA   | 8 data bits, LSB first
// PARITY | even-parity bit (SERIALIZER_PARITY_EN only)
// STOP   | stop bit (line high)
module byte_stream_serializer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       valid,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] count
);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [7:0] CNT_LOAD = 8'(BIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  cyc_cnt_q, cyc_cnt_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
`ifdef SERIALIZER_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic push, pop;

  // FIFO bookkeeping: pop happens only when the framer is idle, which
  // frees a slot so a same-cycle push is still accepted at count=4.
  always_comb begin
    pop      = (state_q == IDLE) && (count_q != 3'd0);
    push     = valid && ((count_q != 3'd4) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (valid && !push) begin
      ovf_d = 1'b1;
    end
  end

  // Framer next-state: every bit slot is timed by a down-counter that is
  // loaded with BIT_CYCLES-1 on entry and advances the FSM at zero.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    cyc_cnt_d = cyc_cnt_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d   = mem_q[rd_ptr_q];
`ifdef SERIALIZER_PARITY_EN
          parity_d  = ^mem_q[rd_ptr_q];
`endif
          cyc_cnt_d = CNT_LOAD;
          state_d   = START;
        end
      end
      START: begin
        if (cyc_cnt_q == 8'd0) begin
          cyc_cnt_d = CNT_LOAD;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
      DATA: begin
        if (cyc_cnt_q == 8'd0) begin
          cyc_cnt_d = CNT_LOAD;
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (cyc_cnt_q == 8'd0) begin
          cyc_cnt_d = CNT_LOAD;
          state_d   = STOP;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
`endif
      STOP: begin
        if (cyc_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current state, registered one clock later.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
`ifdef SERIALIZER_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and discards buffered bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'd0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      shreg_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      cyc_cnt_q <= 8'd0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      cyc_cnt_q <= cyc_cnt_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign count    = count_q;

endmodule

// File: tb/tb_byte_stream_serializer.sv
// Directed bench for byte_stream_serializer at BIT_CYCLES=4. Expected line
// waveforms come from a frame model of back-to-back frames started by the
// first accepted byte.
module tb_byte_stream_serializer;

  localparam int BC = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int P  = FL * BC + 1;
  localparam int NL = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'd0;
  logic       valid = 1'b0;
  logic       tx, busy, overflow;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  logic       sv [NL];
  logic [7:0] sd [NL];
  logic       tx_log [NL];
  logic       busy_log [NL];
  logic       ovf_log [NL];
  logic [2:0] cnt_log [NL];
  logic [7:0] exp_q [$];

  byte_stream_serializer #(.BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .din(din), .valid(valid),
    .tx(tx), .busy(busy), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NL; i++) begin
      sv[i] = 1'b0;
      sd[i] = 8'd0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b1;
    din = 8'hFF;
    repeat (3) tick();
    rst = 1'b0;
    valid = 1'b0;
  endtask

  // Log index n holds outputs sampled after the n-th edge; edge 0 samples sv[0].
  task automatic run(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      valid = sv[n];
      din   = sd[n];
      tick();
      tx_log[n]   = tx;
      busy_log[n] = busy;
      ovf_log[n]  = overflow;
      cnt_log[n]  = count;
    end
    valid = 1'b0;
  endtask

  function automatic logic exp_tx(int n);
    int j, r, slot;
    if (n < 1) return 1'b1;
    j = (n - 1) / P;
    r = (n - 1) % P;
    if (j >= exp_q.size()) return 1'b1;
    if (r == 0) return 1'b1;
    slot = (r - 1) / BC;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return exp_q[j][slot-1];
`ifdef SERIALIZER_PARITY_EN
    if (slot == 9) return ^exp_q[j];
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int n);
    int j, r;
    if (n < 1) return 1'b0;
    j = (n - 1) / P;
    r = (n - 1) % P;
    if (j >= exp_q.size()) return 1'b0;
    return (r < FL * BC);
  endfunction

  // Compare each frame window (plus one trailing idle window) as packed words.
  task automatic check_frames(input string tag);
    logic [63:0] ot, et, ob, eb;
    for (int j = 0; j <= exp_q.size(); j++) begin
      ot = '0; et = '0; ob = '0; eb = '0;
      for (int r = 0; r < P; r++) begin
        ot[r] = tx_log[1 + j*P + r];
        et[r] = exp_tx(1 + j*P + r);
        ob[r] = busy_log[1 + j*P + r];
        eb[r] = exp_busy(1 + j*P + r);
      end
      chk($sformatf("%s_tx_f%0d", tag, j), ot, et);
      chk($sformatf("%s_busy_f%0d", tag, j), ob, eb);
    end
  endtask

  initial begin
    int first_low, busy_cnt, gap, f, pe;
    logic [2:0] peak;
    logic seen_activity;

    // Reset state, with valid held high to show it is ignored during reset.
    do_reset();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_count", count, 3'd0);

    // Single byte 0xA5: latency, frame shape, busy length.
    clear_stim();
    sv[0] = 1'b1; sd[0] = 8'hA5;
    exp_q.push_back(8'hA5);
    run(2 * P + 4);
    chk("single_count_e0", cnt_log[0], 3'd1);
    chk("single_count_e1", cnt_log[1], 3'd0);
    first_low = -1;
    busy_cnt = 0;
    for (int n = 0; n < 2 * P + 4; n++) begin
      if (first_low < 0 && tx_log[n] == 1'b0) first_low = n;
      if (busy_log[n]) busy_cnt++;
    end
    chk("single_latency", 64'(first_low), 64'd2);
    chk("single_busy_len", 64'(busy_cnt), 64'(FL * BC));
    check_frames("single");

    // Byte 0x07: odd popcount, so the parity bit (when present) is 1.
    do_reset();
    clear_stim();
    sv[0] = 1'b1; sd[0] = 8'h07;
    exp_q.push_back(8'h07);
    run(2 * P + 4);
    check_frames("x07");

    // Overflow: six consecutive bytes, the sixth is dropped.
    do_reset();
    clear_stim();
    for (int i = 0; i < 6; i++) begin
      sv[i] = 1'b1;
      sd[i] = 8'(i + 1);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(i + 1));
    run(6 * P + 4);
    chk("ovf_count_e3", cnt_log[3], 3'd3);
    chk("ovf_count_e4", cnt_log[4], 3'd4);
    chk("ovf_flag_e4", ovf_log[4], 1'b0);
    chk("ovf_flag_e5", ovf_log[5], 1'b1);
    chk("ovf_flag_end", ovf_log[6 * P + 3], 1'b1);
    peak = 3'd0;
    for (int n = 0; n < 6 * P + 4; n++) if (cnt_log[n] > peak) peak = cnt_log[n];
    chk("ovf_peak", peak, 3'd4);
    check_frames("ovf");

    // Simultaneous push and pop with a full FIFO in IDLE.
    do_reset();
    clear_stim();
    pe = FL * BC + 2;
    sv[0] = 1'b1; sd[0] = 8'h11;
    sv[2] = 1'b1; sd[2] = 8'h22;
    sv[3] = 1'b1; sd[3] = 8'h33;
    sv[4] = 1'b1; sd[4] = 8'h44;
    sv[5] = 1'b1; sd[5] = 8'h55;
    sv[pe] = 1'b1; sd[pe] = 8'h66;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    run(7 * P + 4);
    chk("pp_count_before", cnt_log[pe - 1], 3'd4);
    chk("pp_count_after", cnt_log[pe], 3'd4);
    chk("pp_ovf", ovf_log[7 * P + 3], 1'b0);
    check_frames("pp");

    // Back-to-back: exactly one idle clock between two frames.
    do_reset();
    clear_stim();
    sv[0] = 1'b1; sd[0] = 8'h3C;
    sv[1] = 1'b1; sd[1] = 8'hC3;
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    run(3 * P + 4);
    f = -1;
    for (int n = 2; n < 3 * P + 4; n++) if (f < 0 && busy_log[n] == 1'b0) f = n;
    gap = 0;
    if (f >= 0) begin
      for (int n = f; n < 3 * P + 4; n++) begin
        if (busy_log[n]) break;
        if (tx_log[n]) gap++;
      end
    end
    chk("b2b_gap", 64'(gap), 64'd1);
    check_frames("b2b");

    // Reset mid-frame with two bytes buffered.
    do_reset();
    clear_stim();
    sv[0] = 1'b1; sd[0] = 8'h00;
    sv[1] = 1'b1; sd[1] = 8'hAA;
    sv[2] = 1'b1; sd[2] = 8'h55;
    run(15);
    chk("mid_busy_before", busy_log[14], 1'b1);
    chk("mid_count_before", cnt_log[14], 3'd2);
    rst = 1'b1;
    valid = 1'b1;
    din = 8'h99;
    tick();
    chk("mid_tx", tx, 1'b1);
    chk("mid_busy", busy, 1'b0);
    chk("mid_count", count, 3'd0);
    chk("mid_ovf", overflow, 1'b0);
    rst = 1'b0;
    valid = 1'b0;
    seen_activity = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (busy || !tx || count != 3'd0) seen_activity = 1'b1;
    end
    chk("mid_quiet", seen_activity, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
